// File: rtl/seg_pkg.sv
// Shared types, constants and the hex-to-segment encoding for the segment
// display update master.
package seg_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int BLINK_ADDR = 8;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMP,
        ST_WRITE
    } state_t;

    // Active-low byte {~dp, ~g..~a}; blank overrides both digit and dp.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble,
                                              input logic       dp,
                                              input logic       blank);
        logic [6:0] seg_n;
        case (nibble)
            4'h0: seg_n = 7'h40;
            4'h1: seg_n = 7'h79;
            4'h2: seg_n = 7'h24;
            4'h3: seg_n = 7'h30;
            4'h4: seg_n = 7'h19;
            4'h5: seg_n = 7'h12;
            4'h6: seg_n = 7'h02;
            4'h7: seg_n = 7'h78;
            4'h8: seg_n = 7'h00;
            4'h9: seg_n = 7'h10;
            4'hA: seg_n = 7'h08;
            4'hB: seg_n = 7'h03;
            4'hC: seg_n = 7'h46;
            4'hD: seg_n = 7'h21;
            4'hE: seg_n = 7'h06;
            4'hF: seg_n = 7'h0E;
            default: seg_n = 7'h7F;
        endcase
        return blank ? SEG_BLANK : {~dp, seg_n};
    endfunction

endpackage

// File: rtl/seg_hex_encoder.sv
// Combinational encoder: one hex digit plus dp/blank flags to a segment byte.
module seg_hex_encoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    assign seg = hex_to_seg(nibble, dp, blank);

endmodule

// File: rtl/segment_update_master.sv
// Avalon-MM write master that pushes only the changed bytes of a display
// image (digits + blink mask) to the segment display slave.
module segment_update_master #(
    parameter int NUM_DIGITS = seg_pkg::NUM_DIGITS,
    parameter int BLINK_ADDR = seg_pkg::BLINK_ADDR,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    upd_req,
    input  logic [4*NUM_DIGITS-1:0] upd_digits,
    input  logic [NUM_DIGITS-1:0]   upd_dp,
    input  logic [NUM_DIGITS-1:0]   upd_blank,
    input  logic [7:0]              upd_blink,
    output logic                    upd_ack,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   m_address,
    output logic                    m_write,
    output logic [7:0]              m_writedata,
    input  logic                    m_waitrequest
);
    import seg_pkg::*;

    localparam int NUM_REGS = NUM_DIGITS + 1;
    localparam int IDX_W    = $clog2(NUM_REGS);

    state_t                  state_reg, state_next;
    logic                    valid_reg, valid_next;
    logic [NUM_REGS-1:0]     dirty_reg, dirty_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic                    upd_ack_reg, upd_ack_next;
    logic                    busy_reg, busy_next;
    logic                    m_write_reg, m_write_next;
    logic [ADDR_WIDTH-1:0]   m_address_reg, m_address_next;
    logic [7:0]              m_writedata_reg, m_writedata_next;

    logic [7:0]              enc_seg [NUM_DIGITS];
    logic [7:0]              image_reg [NUM_REGS];
    logic [7:0]              shadow_reg [NUM_REGS];
    logic [NUM_REGS-1:0]     dirty_cmp;
    logic [NUM_REGS-1:0]     pick_vec;
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_any;
    logic                    capture;
    logic                    write_done;

    function automatic logic [ADDR_WIDTH-1:0] reg_addr(input logic [IDX_W-1:0] idx);
        if (int'(idx) == NUM_DIGITS) return ADDR_WIDTH'(BLINK_ADDR);
        return ADDR_WIDTH'(idx);
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_enc
            seg_hex_encoder u_enc (
                .nibble (upd_digits[4*gi +: 4]),
                .dp     (upd_dp[gi]),
                .blank  (upd_blank[gi]),
                .seg    (enc_seg[gi])
            );

            always_ff @(posedge clk) begin
                if (capture) image_reg[gi] <= enc_seg[gi];
            end
        end

        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dirty
            assign dirty_cmp[gi] = !valid_reg || (image_reg[gi] != shadow_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (capture) image_reg[NUM_DIGITS] <= upd_blink;
        if (write_done) shadow_reg[idx_reg] <= image_reg[idx_reg];
    end

    // Lowest pending entry: the fresh compare result in CMP, otherwise the
    // remaining dirty set once the current entry is retired.
    always_comb begin
        pick_vec = (state_reg == ST_CMP) ? dirty_cmp
                                         : (dirty_reg & ~(NUM_REGS'(1) << idx_reg));
        pick_any = |pick_vec;
        pick_idx = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (pick_vec[i]) pick_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_next       = state_reg;
        valid_next       = valid_reg;
        dirty_next       = dirty_reg;
        idx_next         = idx_reg;
        upd_ack_next     = 1'b0;
        busy_next        = busy_reg;
        m_write_next     = m_write_reg;
        m_address_next   = m_address_reg;
        m_writedata_next = m_writedata_reg;
        capture          = 1'b0;
        write_done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (upd_req) begin
                    capture      = 1'b1;
                    state_next   = ST_CMP;
                    upd_ack_next = 1'b1;
                    busy_next    = 1'b1;
                end
            end
            ST_CMP: begin
                dirty_next = dirty_cmp;
                if (pick_any) begin
                    state_next       = ST_WRITE;
                    idx_next         = pick_idx;
                    m_write_next     = 1'b1;
                    m_address_next   = reg_addr(pick_idx);
                    m_writedata_next = image_reg[pick_idx];
                end else begin
                    state_next = ST_IDLE;
                    busy_next  = 1'b0;
                end
            end
            ST_WRITE: begin
                if (!m_waitrequest) begin
                    write_done = 1'b1;
                    dirty_next = pick_vec;
                    if (pick_any) begin
                        idx_next         = pick_idx;
                        m_address_next   = reg_addr(pick_idx);
                        m_writedata_next = image_reg[pick_idx];
                    end else begin
                        state_next       = ST_IDLE;
                        valid_next       = 1'b1;
                        busy_next        = 1'b0;
                        m_write_next     = 1'b0;
                        m_address_next   = '0;
                        m_writedata_next = '0;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            valid_reg       <= 1'b0;
            dirty_reg       <= '0;
            idx_reg         <= '0;
            upd_ack_reg     <= 1'b0;
            busy_reg        <= 1'b0;
            m_write_reg     <= 1'b0;
            m_address_reg   <= '0;
            m_writedata_reg <= '0;
        end else begin
            state_reg       <= state_next;
            valid_reg       <= valid_next;
            dirty_reg       <= dirty_next;
            idx_reg         <= idx_next;
            upd_ack_reg     <= upd_ack_next;
            busy_reg        <= busy_next;
            m_write_reg     <= m_write_next;
            m_address_reg   <= m_address_next;
            m_writedata_reg <= m_writedata_next;
        end
    end

    assign upd_ack     = upd_ack_reg;
    assign busy        = busy_reg;
    assign m_write     = m_write_reg;
    assign m_address   = m_address_reg;
    assign m_writedata = m_writedata_reg;

endmodule

// File: doc/segment_update_master.md
# segment_update_master

Avalon-MM write master that sequences updates to the 8-digit segment display register slave. It captures a requested display image (hex digits, decimal points, blanking, blink mask), encodes each digit to a segment byte, and writes only the slave registers whose value changed since the last update. The block sits between watch/timekeeping logic and the segment slave, and removes that logic's need to issue bus cycles.

## Interface
- `NUM_DIGITS`, 8: digit registers at slave addresses 0..NUM_DIGITS-1.
- `BLINK_ADDR`, 8: slave address of the blink-mask register.
- `ADDR_WIDTH`, 4: master address width.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `upd_req` in 1: update request (level); held until `upd_ack`.
- `upd_digits` in 32: nibble i (`[4i+3:4i]`) is the hex value for digit i.
- `upd_dp` in 8: bit i lights the decimal point of digit i.
- `upd_blank` in 8: bit i blanks digit i entirely.
- `upd_blink` in 8: blink mask, written verbatim to `BLINK_ADDR`.
- `upd_ack` out 1: one-cycle pulse; the request was captured.
- `busy` out 1: high from capture until the last write completes.
- `m_address` out ADDR_WIDTH: word address of the slave register.
- `m_write` out 1: write strobe.
- `m_writedata` out 8: write data.
- `m_waitrequest` in 1: slave stall. A write completes on a rising edge with `m_write`=1 and `m_waitrequest`=0.

## Operation
- **Segment byte encoding:** active-low, `{~dp, ~g,~f,~e,~d,~c,~b,~a}`.
  - Hex patterns with dp off: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
  - dp set clears bit 7.
  - blank forces FF, overriding both digit and dp.
- **Image:** 9 bytes. Entries 0..7 are the encoded digits; entry 8 is `upd_blink`.
- **Shadow:** 9 bytes holding the last values written to the slave, plus a `valid` flag.
  - Reset clears `valid`.
  - The first update after reset therefore writes all 9 registers.
- **FSM states:** IDLE, CMP, WRITE.
  - IDLE: when `upd_req`=1, register the image, go to CMP, assert `upd_ack` (one cycle) and `busy`.
  - CMP: `dirty[i]` = `!valid` OR image[i] != shadow[i]. If dirty is nonzero, go to WRITE with idx = lowest set bit; otherwise go to IDLE.
  - WRITE: drive `m_write`=1, `m_address`=idx (8 maps to `BLINK_ADDR`), `m_writedata`=image[idx].
    - On completion: shadow[idx] ← image[idx], clear `dirty[idx]`, idx ← next lowest dirty bit (no idle cycle between writes).
    - After the last dirty entry: set `valid`, go to IDLE.
- **Requests while busy:** `upd_req` is ignored (not queued). The requester keeps it asserted and is acked on return to IDLE.
- **Input stability:** `upd_*` inputs are sampled only on the capture edge; later changes do not affect the update in flight.
- **Reset mid-write:** the FSM returns to IDLE, all outputs go low, `valid` clears. A partially written image is fully rewritten on the next update.

## Timing
- **Reset values:** `upd_ack`=0, `busy`=0, `m_write`=0, `m_address`=0, `m_writedata`=0. All outputs are registered.
- **Request timeline:** request captured at edge k.
  - Cycle k+1: `upd_ack`=1, `busy`=1 (state CMP).
  - Cycle k+2: first write presented.
- **Zero-wait update of n dirty registers:** writes occupy cycles k+2..k+n+1; `busy` falls at edge k+n+2.
- **No-change update:** `busy` is high for exactly one cycle (k+1).
- **Stalls:** `m_address`/`m_writedata` stay stable while `m_waitrequest`=1; each wait cycle adds one cycle of latency.
- **Back-to-back requests:** the earliest next capture is the edge on which `busy` returns low in IDLE, i.e. `upd_req` sampled in the first IDLE cycle.

## Structure
- Package `seg_pkg`:
  - constants `NUM_DIGITS`, `BLINK_ADDR`, `SEG_BLANK`=8'hFF
  - FSM state enum
  - function `hex_to_seg(nibble, dp, blank)` returning the 8-bit byte
- Sub-module `seg_hex_encoder`: combinational, 8 instances or one shared by idx. It encodes digit, dp and blank into a byte.
- The priority encoder for the lowest dirty bit stays inline in the top.

## Test plan
- **After reset:** `upd_digits`=32'h76543210, dp=0, blank=0, blink=0, no wait.
  - Expect 9 writes on consecutive cycles: addr 0..7 with data C0,F9,A4,B0,99,92,82,F8; then addr 8 with 00.
  - `busy` is high for 10 cycles.
- **Single change:** same image except digit 3 = 9 and dp[3]=1. Expect exactly one write: addr 3, data 10.
- **Identical request:** repeat the previous request. Expect `upd_ack`, `busy` high for 1 cycle, no `m_write`.
- **Blank plus blink under stall:** blank=8'h80, blink=8'h03, `m_waitrequest` high 3 cycles per write.
  - Expect addr 7 data FF, then addr 8 data 03.
  - Address and data are held stable through the stalls.
- **Request during busy:** `upd_req` held, with inputs changed mid-update.
  - The in-flight writes use the captured values.
  - A second `upd_ack` arrives only after `busy` falls.
  - The second update writes only the bytes that differ.
- **Reset mid-update:** assert `reset` after the 4th write. Outputs are 0 immediately; the next request writes all 9 registers.
